// File: rtl/gs_rref_unload_pkg.sv
// Shared types and sizing helpers for the reduced-matrix row unloader.
// The optional zero-row counter is enabled by defining GS_UNLOAD_ZCNT_EN.
package gs_rref_unload_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   localparam int READ_DELAY_DEF = 2;

   // Address width that never collapses to zero bits for a one-row matrix.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Smallest prefetch FIFO that sustains one row per cycle.
   function automatic int fifo_depth(input int rd);
      return rd + 1;
   endfunction

endpackage

// File: rtl/gs_rref_unload_fifo.sv
// Prefetch FIFO for gs_rref_unload: holds {row index, row data} pairs
// between the row-memory read pipe and the valid/ready output.
module gs_unload_fifo
   import gs_rref_unload_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 3
) (
   input  logic                         clk,
   input  logic                         rst_b,
   input  logic                         push,
   input  logic [W-1:0]                 din,
   input  logic                         pop,
   output logic [W-1:0]                 dout,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   cnt
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & ((cnt != CNT_FULL) | do_pop);
   assign dout    = store[rd_ptr];

   // Storage, pointers and occupancy; push and pop together keep cnt unchanged.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            store[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            store[wr_ptr] <= din;
            wr_ptr        <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/gs_rref_unload.sv
// Streams rows 0..k-1 of the reduced matrix out of the row memory over valid/ready.
// Define GS_UNLOAD_ZCNT_EN to add the zero_rows (all-zero accepted rows) counter port.
module gs_rref_unload
   import gs_rref_unload_pkg::*;
#(
   parameter int k          = 6,
   parameter int l          = 4,
   parameter int READ_DELAY = READ_DELAY_DEF
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [addr_w(k)-1:0]    mem_addr,
   output logic                    mem_en,
   input  logic [l-1:0]            mem_dina,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [l-1:0]            out_data,
   output logic [addr_w(k)-1:0]    out_idx,
   output logic                    out_last
`ifdef GS_UNLOAD_ZCNT_EN
   ,
   output logic [$clog2(k+1)-1:0]  zero_rows
`endif
);
   localparam int AW = addr_w(k);
   localparam int FD = fifo_depth(READ_DELAY);
   localparam int CW = $clog2(FD + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(k - 1);
   localparam logic [CW:0]   FD_V      = (CW + 1)'(FD);

   state_t              state;
   state_t              state_nx;
   logic [READ_DELAY-1:0] flag_pipe;
   logic [AW-1:0]       idx_pipe [READ_DELAY];
   logic [CW-1:0]       inflight;
   logic [CW-1:0]       fifo_cnt;
   logic [CW:0]         used;
   logic                fifo_empty;
   logic                pop;
   logic                push;
   logic [AW+l-1:0]     fifo_dout;

   assign pop       = out_valid & out_ready;
   assign push      = flag_pipe[READ_DELAY-1];
   assign out_valid = ~fifo_empty;
   assign out_idx   = fifo_dout[AW+l-1:l];
   assign out_data  = fifo_dout[l-1:0];
   assign out_last  = out_valid & (out_idx == LAST_ADDR);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FIN);

   // Number of reads still travelling through the memory pipe.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_DELAY; i++) begin
         inflight = inflight + CW'(flag_pipe[i]);
      end
   end

   // A row popped this cycle returns its credit immediately, so the FIFO never starves.
   always_comb begin
      used = {1'b0, inflight} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};
   end

   // Next-state and read-issue decode.
   always_comb begin
      state_nx = state;
      mem_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nx = ST_FETCH;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (used < FD_V) begin
               mem_en = 1'b1;
               if (mem_addr == LAST_ADDR) begin
                  state_nx = ST_DRAIN;
               end else begin
                  state_nx = ST_FETCH;
               end
            end else begin
               state_nx = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (pop && (out_idx == LAST_ADDR)) begin
               state_nx = ST_FIN;
            end else begin
               state_nx = ST_DRAIN;
            end
         end
         ST_FIN:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Read address (held at k-1 after the final issue) and the issue-flag pipe.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mem_addr  <= '0;
         flag_pipe <= '0;
         for (int i = 0; i < READ_DELAY; i++) begin
            idx_pipe[i] <= '0;
         end
      end else begin
         if ((state == ST_IDLE) && start) begin
            mem_addr <= '0;
         end else if (mem_en && (mem_addr != LAST_ADDR)) begin
            mem_addr <= mem_addr + AW'(1);
         end
         flag_pipe[0] <= mem_en;
         idx_pipe[0]  <= mem_addr;
         for (int i = 1; i < READ_DELAY; i++) begin
            flag_pipe[i] <= flag_pipe[i-1];
            idx_pipe[i]  <= idx_pipe[i-1];
         end
      end
   end

   gs_unload_fifo #(
      .W     (AW + l),
      .DEPTH (FD)
   ) u_fifo (
      .clk   (clk),
      .rst_b (rst_b),
      .push  (push),
      .din   ({idx_pipe[READ_DELAY-1], mem_dina}),
      .pop   (pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .cnt   (fifo_cnt)
   );

`ifdef GS_UNLOAD_ZCNT_EN
   // Rank-deficiency indicator: accepted rows that are entirely zero.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         zero_rows <= '0;
      end else if ((state == ST_IDLE) && start) begin
         zero_rows <= '0;
      end else if (pop && (out_data == '0)) begin
         zero_rows <= zero_rows + ($clog2(k+1))'(1);
      end
   end
`endif

endmodule

// File: tb/tb_gs_rref_unload.sv
// Directed, table-driven bench for gs_rref_unload (k=6 and k=1 instances).
// Zero-row counter checks are compiled in when GS_UNLOAD_ZCNT_EN is defined.
module tb_gs_rref_unload;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       start, out_ready;
   logic       busy, done, mem_en, out_valid, out_last;
   logic [2:0] mem_addr, out_idx;
   logic [3:0] mem_dina, out_data;

   logic       start1, ready1;
   logic       busy1, done1, mem_en1, out_valid1, out_last1;
   logic [0:0] mem_addr1, out_idx1;
   logic [3:0] mem_dina1, out_data1;
`ifdef GS_UNLOAD_ZCNT_EN
   logic [2:0] zero_rows;
   logic [0:0] zero_rows1;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gs_rref_unload #(.k(6), .l(4), .READ_DELAY(2)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_dina(mem_dina),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last)
`ifdef GS_UNLOAD_ZCNT_EN
      , .zero_rows(zero_rows)
`endif
   );

   gs_rref_unload #(.k(1), .l(4), .READ_DELAY(2)) dut1 (
      .clk(clk), .rst_b(rst_b), .start(start1), .busy(busy1), .done(done1),
      .mem_addr(mem_addr1), .mem_en(mem_en1), .mem_dina(mem_dina1),
      .out_valid(out_valid1), .out_ready(ready1), .out_data(out_data1),
      .out_idx(out_idx1), .out_last(out_last1)
`ifdef GS_UNLOAD_ZCNT_EN
      , .zero_rows(zero_rows1)
`endif
   );

   // Row memory models: two-cycle read latency from mem_en/mem_addr.
   logic [3:0] tb_mem [6];
   logic [3:0] rd_a, rd_b, mem1_val, rd1_a, rd1_b;
   assign mem_dina  = rd_b;
   assign mem_dina1 = rd1_b;
   always @(posedge clk) begin
      rd_a  <= mem_en ? tb_mem[mem_addr] : 4'h0;
      rd_b  <= rd_a;
      rd1_a <= mem_en1 ? mem1_val : 4'h0;
      rd1_b <= rd1_a;
   end

   typedef struct {
      logic [23:0] rows;       // row i at bits [4*i +: 4]
      logic [7:0]  ready_pat;  // out_ready for cycle c is bit c%8
      int          stall;      // out_ready forced 0 for cycles <= stall
      int          restart;    // cycle at which start is re-pulsed (-1 none)
      int          exp_first;  // first out_valid cycle after start (0 = skip)
      int          exp_done;   // done cycle after start (0 = skip)
      int          exp_zero;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_txn(input vec_t v);
      int cyc, nexp, issued, popped, first, done_cyc, last_hs, max_cnt, stall_issues;
      logic       prev_stall;
      logic [3:0] prev_data;
      logic [2:0] prev_idx;
      logic [3:0] exp_row;
      logic       hs;
      cyc = 0; nexp = 0; issued = 0; popped = 0; first = -1; done_cyc = -1;
      last_hs = -1; max_cnt = 0; stall_issues = 0; prev_stall = 1'b0;
      prev_data = 4'h0; prev_idx = 3'd0;
      for (int i = 0; i < 6; i++) tb_mem[i] = v.rows[4*i +: 4];
      start = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (done_cyc < 0 && cyc < 200) begin
         start = (cyc == v.restart);
         out_ready = (cyc > v.stall) ? v.ready_pat[cyc % 8] : 1'b0;
         @(negedge clk);
         hs = out_valid & out_ready;
         check("busy_high", busy, 1);
         if (mem_en) begin
            check("mem_addr", mem_addr, issued);
            check("credit_gate", ((issued - popped - int'(hs)) < 3), 1);
            issued++;
            if (cyc <= v.stall) stall_issues++;
         end
         if (int'(dut.u_fifo.cnt) > max_cnt) max_cnt = int'(dut.u_fifo.cnt);
         if (out_valid && first < 0) begin
            first = cyc;
            if (v.exp_first > 0) check("first_valid_cycle", first, v.exp_first);
         end
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
            check("hold_idx", out_idx, prev_idx);
         end
         if (hs) begin
            exp_row = v.rows[4*nexp +: 4];
            check("row_idx", out_idx, nexp);
            check("row_data", out_data, exp_row);
            check("row_last", out_last, (nexp == 5));
            nexp++;
            popped++;
            last_hs = cyc;
         end
         prev_stall = out_valid & ~out_ready;
         prev_data  = out_data;
         prev_idx   = out_idx;
         if (done) begin
            done_cyc = cyc;
            check("done_after_last_hs", done_cyc, last_hs + 1);
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (done_cyc < 0) check("done_timeout", 0, 1);
      check("rows_delivered", nexp, 6);
      check("reads_issued", issued, 6);
      check("fifo_cnt_max_le3", (max_cnt <= 3), 1);
      if (v.exp_done > 0) check("done_cycle", done_cyc, v.exp_done);
      if (v.stall > 0) check("reads_during_stall", stall_issues, 3);
`ifdef GS_UNLOAD_ZCNT_EN
      check("zero_rows", zero_rows, v.exp_zero);
`endif
      start = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         check("idle_mem_en", mem_en, 0);
         check("idle_valid", out_valid, 0);
         check("mem_addr_hold", mem_addr, 5);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1);
   end

   initial begin
      int first1, done1_cyc, issues1;
      tbl[0] = '{24'h654321, 8'hFF,       0, -1, 4, 10, 0};
      tbl[1] = '{24'hEDCBA9, 8'b10011001, 0,  3, 4,  0, 0};
      tbl[2] = '{24'h030050, 8'hFF,       0, 10, 4, 10, 4};
      tbl[3] = '{24'h21870F, 8'h55,       0, -1, 4,  0, 1};
      tbl[4] = '{24'h6A5C3E, 8'hFF,      20, -1, 4, 27, 0};

      rst_b = 1'b0; start = 1'b0; out_ready = 1'b0;
      start1 = 1'b0; ready1 = 1'b0; mem1_val = 4'hB;
      for (int i = 0; i < 6; i++) tb_mem[i] = 4'h0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_k1_last", out_last1, 0);
`ifdef GS_UNLOAD_ZCNT_EN
      check("rst_zero_rows", zero_rows, 0);
`endif
      @(negedge clk); rst_b = 1'b1;
      @(posedge clk); #1;

      for (int t = 0; t < 5; t++) run_txn(tbl[t]);

      // Reset asserted mid-DRAIN while row 3 waits at the FIFO head.
      for (int i = 0; i < 6; i++) tb_mem[i] = 4'(i + 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 8; c++) begin
         out_ready = (c <= 6);
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      check("pre_rst_valid", out_valid, 1);
      check("pre_rst_idx", out_idx, 3);
      rst_b = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_mem_en", mem_en, 0);
      check("mid_rst_last", out_last, 0);
      check("mid_rst_idx", out_idx, 0);
      check("mid_rst_mem_addr", mem_addr, 0);
      @(negedge clk); rst_b = 1'b1;
      @(posedge clk); #1;
      run_txn(tbl[0]);

      // k=1 instance: one read, one row flagged last.
      first1 = -1; done1_cyc = -1; issues1 = 0;
      start1 = 1'b1; ready1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int c = 1; c < 12; c++) begin
         @(negedge clk);
         if (mem_en1) issues1++;
         if (out_valid1 && first1 < 0) begin
            first1 = c;
            check("k1_data", out_data1, 4'hB);
            check("k1_idx", out_idx1, 0);
            check("k1_last", out_last1, 1);
         end
         if (done1) done1_cyc = c;
         @(posedge clk); #1;
      end
      check("k1_first_valid", first1, 4);
      check("k1_done", done1_cyc, 5);
      check("k1_reads", issues1, 1);
      check("k1_busy_after", busy1, 0);
`ifdef GS_UNLOAD_ZCNT_EN
      check("k1_zero_rows", zero_rows1, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
